// File: rtl/dma_csr_mc_if.sv
// Register-port and master-side signal bundle for the multi-channel DMA
// control slave. The slave modport is the controller's view. The master modport
// is the view of the CPU and of the read/write masters that drive it.
interface dma_csr_mc_if #(
   parameter int DATA_W = 32
);
   // Avalon-style register port
   logic              iChipselect_n;
   logic              iWrite;
   logic              iRead;
   logic [4:0]        iAddress;
   logic [DATA_W-1:0] iWritedata;
   logic [DATA_W-1:0] oReaddata;

   // Shared read/write master launch interface
   logic              iMW_done;
   logic              oStart;
   logic [DATA_W-1:0] oRM_startaddress;
   logic [DATA_W-1:0] oWM_startaddress;
   logic [DATA_W-1:0] oLength;
   logic [1:0]        oSize;
   logic [1:0]        oChannel;
   logic              oIrq;

   modport slave (
      input  iChipselect_n, iWrite, iRead, iAddress, iWritedata, iMW_done,
      output oReaddata, oStart, oRM_startaddress, oWM_startaddress,
             oLength, oSize, oChannel, oIrq
   );

   modport master (
      output iChipselect_n, iWrite, iRead, iAddress, iWritedata, iMW_done,
      input  oReaddata, oStart, oRM_startaddress, oWM_startaddress,
             oLength, oSize, oChannel, oIrq
   );
endinterface

// File: rtl/dma_csr_mc.sv
// Multi-channel DMA control slave. Each channel holds a transfer descriptor
// and its status. The CPU arms channels through the register port. A
// round-robin arbiter launches one transfer at a time to the shared masters.
// Completion raises a maskable per-channel interrupt.
module dma_csr_mc #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 32
) (
   input  logic        iClk,
   input  logic        iReset,
   dma_csr_mc_if.slave bus
);
   localparam logic [1:0] LAST_CH  = 2'(NUM_CH - 1);
   localparam logic [2:0] OFF_RM   = 3'd0;
   localparam logic [2:0] OFF_WM   = 3'd1;
   localparam logic [2:0] OFF_LEN  = 3'd2;
   localparam logic [2:0] OFF_CTRL = 3'd3;
   localparam logic [2:0] OFF_STAT = 3'd7;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

   state_t            stateReg, stateNext;
   logic              startComb;
   logic [1:0]        curChReg, lastGrantReg;
   logic [DATA_W-1:0] rmOutReg, wmOutReg, lenOutReg;
   logic [1:0]        sizeOutReg;
   logic [DATA_W-1:0] rdataReg, rdMux;
   logic              irqReg;

   logic              wrEn, rdEn, chValid;
   logic [1:0]        chSel;
   logic [2:0]        offSel;

   // Per-channel views gathered into fixed four-entry arrays. Channels that do
   // not exist read as zero and never pend.
   logic [DATA_W-1:0] rmAddrArr [4];
   logic [DATA_W-1:0] wmAddrArr [4];
   logic [DATA_W-1:0] lenArr    [4];
   logic [1:0]        sizeArr   [4];
   logic [3:0]        goVec, irqEnVec, doneVec, busyVec, errVec, pendingVec;

   logic              grantFound;
   logic [1:0]        grantCh, candCh;

   // A write that also has iRead high is treated as a write only
   assign wrEn    = ~bus.iChipselect_n & bus.iWrite;
   assign rdEn    = ~bus.iChipselect_n & bus.iRead & ~bus.iWrite;
   assign chSel   = bus.iAddress[4:3];
   assign offSel  = bus.iAddress[2:0];
   assign chValid = (int'(chSel) < NUM_CH);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : gCh
         if (gi < NUM_CH) begin : gLive
            logic [DATA_W-1:0] rmAddrReg, wmAddrReg, lenReg;
            logic [1:0]        sizeReg;
            logic              goReg, irqEnReg, doneReg, busyReg, errReg, pendingReg;
            logic              chWr, launchThis, finishThis;

            assign chWr       = wrEn && (chSel == 2'(gi));
            assign launchThis = (stateReg == LAUNCH) && (curChReg == 2'(gi));
            assign finishThis = (stateReg == FINISH) && (curChReg == 2'(gi));

            // Descriptor/status update: CPU writes first, then FSM events.
            // The FINISH set of DONE is applied last so it wins over a same-cycle W1C.
            always_ff @(posedge iClk or posedge iReset) begin
               if (iReset) begin
                  rmAddrReg  <= '0;
                  wmAddrReg  <= '0;
                  lenReg     <= '0;
                  sizeReg    <= '0;
                  goReg      <= 1'b0;
                  irqEnReg   <= 1'b0;
                  doneReg    <= 1'b0;
                  busyReg    <= 1'b0;
                  errReg     <= 1'b0;
                  pendingReg <= 1'b0;
               end else begin
                  if (chWr && !busyReg && !pendingReg) begin
                     case (offSel)
                        OFF_RM:  rmAddrReg <= bus.iWritedata;
                        OFF_WM:  wmAddrReg <= bus.iWritedata;
                        OFF_LEN: lenReg    <= bus.iWritedata;
                        OFF_CTRL: begin
                           irqEnReg <= bus.iWritedata[1];
                           sizeReg  <= bus.iWritedata[3:2];
                           if (bus.iWritedata[0] && (lenReg == '0)) begin
                              // Nothing to move: complete at once with an error
                              errReg  <= 1'b1;
                              doneReg <= 1'b1;
                              goReg   <= 1'b0;
                           end else if (bus.iWritedata[0]) begin
                              goReg      <= 1'b1;
                              pendingReg <= 1'b1;
                           end else begin
                              goReg <= 1'b0;
                           end
                        end
                        default: ;
                     endcase
                  end
                  if (chWr && (offSel == OFF_STAT) && bus.iWritedata[0]) begin
                     doneReg <= 1'b0;
                     errReg  <= 1'b0;
                  end
                  if (launchThis) begin
                     pendingReg <= 1'b0;
                     busyReg    <= 1'b1;
                  end
                  if (finishThis) begin
                     busyReg <= 1'b0;
                     doneReg <= 1'b1;
                     goReg   <= 1'b0;
                  end
               end
            end

            assign rmAddrArr[gi]  = rmAddrReg;
            assign wmAddrArr[gi]  = wmAddrReg;
            assign lenArr[gi]     = lenReg;
            assign sizeArr[gi]    = sizeReg;
            assign goVec[gi]      = goReg;
            assign irqEnVec[gi]   = irqEnReg;
            assign doneVec[gi]    = doneReg;
            assign busyVec[gi]    = busyReg;
            assign errVec[gi]     = errReg;
            assign pendingVec[gi] = pendingReg;
         end else begin : gAbsent
            assign rmAddrArr[gi]  = '0;
            assign wmAddrArr[gi]  = '0;
            assign lenArr[gi]     = '0;
            assign sizeArr[gi]    = '0;
            assign goVec[gi]      = 1'b0;
            assign irqEnVec[gi]   = 1'b0;
            assign doneVec[gi]    = 1'b0;
            assign busyVec[gi]    = 1'b0;
            assign errVec[gi]     = 1'b0;
            assign pendingVec[gi] = 1'b0;
         end
      end
   endgenerate

   // Round-robin search for the first pending channel after the last grant
   always_comb begin
      grantFound = 1'b0;
      grantCh    = lastGrantReg;
      candCh     = lastGrantReg;
      for (int k = 0; k < NUM_CH; k++) begin
         candCh = (candCh == LAST_CH) ? 2'd0 : candCh + 2'd1;
         if (!grantFound && pendingVec[candCh]) begin
            grantFound = 1'b1;
            grantCh    = candCh;
         end
      end
   end

   // Next-state logic and the one-cycle launch strobe
   always_comb begin
      stateNext = stateReg;
      startComb = 1'b0;
      case (stateReg)
         IDLE:    if (grantFound) stateNext = LAUNCH;
         LAUNCH: begin
            startComb = 1'b1;
            stateNext = WAIT;
         end
         WAIT:    if (bus.iMW_done) stateNext = FINISH;
         FINISH:  stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // State register, granted-descriptor latch and round-robin pointer
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         stateReg     <= IDLE;
         curChReg     <= '0;
         lastGrantReg <= '0;
         rmOutReg     <= '0;
         wmOutReg     <= '0;
         lenOutReg    <= '0;
         sizeOutReg   <= '0;
      end else begin
         stateReg <= stateNext;
         if ((stateReg == IDLE) && grantFound) begin
            curChReg   <= grantCh;
            rmOutReg   <= rmAddrArr[grantCh];
            wmOutReg   <= wmAddrArr[grantCh];
            lenOutReg  <= lenArr[grantCh];
            sizeOutReg <= sizeArr[grantCh];
         end
         if (stateReg == FINISH) lastGrantReg <= curChReg;
      end
   end

   // Register readback selection; unmapped offsets and channels read zero
   always_comb begin
      rdMux = '0;
      if (chValid) begin
         case (offSel)
            OFF_RM:   rdMux = rmAddrArr[chSel];
            OFF_WM:   rdMux = wmAddrArr[chSel];
            OFF_LEN:  rdMux = lenArr[chSel];
            OFF_CTRL: rdMux = {{(DATA_W-4){1'b0}}, sizeArr[chSel], irqEnVec[chSel], goVec[chSel]};
            OFF_STAT: rdMux = {{(DATA_W-4){1'b0}}, pendingVec[chSel], errVec[chSel],
                               busyVec[chSel], doneVec[chSel]};
            default:  rdMux = '0;
         endcase
      end
   end

   // Registered read data (held between reads) and registered interrupt
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         rdataReg <= '0;
         irqReg   <= 1'b0;
      end else begin
         if (rdEn) rdataReg <= rdMux;
         irqReg <= |(doneVec & irqEnVec);
      end
   end

   assign bus.oReaddata        = rdataReg;
   assign bus.oStart           = startComb;
   assign bus.oRM_startaddress = rmOutReg;
   assign bus.oWM_startaddress = wmOutReg;
   assign bus.oLength          = lenOutReg;
   assign bus.oSize            = sizeOutReg;
   assign bus.oChannel         = curChReg;
   assign bus.oIrq             = irqReg;
endmodule

// File: tb/tb_dma_csr_mc.sv
// Testbench for dma_csr_mc with three channels: register table, transfers,
// round-robin order, error, protection, collision and reset sequences.
module tb_dma_csr_mc;
   localparam int NUM_CH = 3;
   localparam int DATA_W = 32;

   logic iClk = 1'b0;
   logic iReset = 1'b1;
   always #5 iClk = ~iClk;

   dma_csr_mc_if #(.DATA_W(DATA_W)) bus ();
   dma_csr_mc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (.iClk(iClk), .iReset(iReset), .bus(bus));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        doWrite;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] expRead;
      string       name;
   } vec_t;

   typedef struct packed {
      logic [1:0]  ch;
      logic [31:0] rm;
      logic [31:0] wm;
      logic [31:0] len;
      logic [1:0]  size;
   } launch_t;

   vec_t        vecs [12];
   launch_t     launchQ [$];
   logic [31:0] readQ [$];
   string       readNameQ [$];
   launch_t     monExp;
   int          startCount = 0;
   int          cycleCnt = 0;
   int          lastStartCycle = -100;
   logic        prevStart = 1'b0;
   logic [31:0] lastReadExp = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] addr(input int ch, input int off);
      return {2'(ch), 3'(off)};
   endfunction

   function automatic launch_t mk(input int ch, input logic [31:0] rm, input logic [31:0] wm,
                                  input logic [31:0] len, input int size);
      launch_t l;
      l.ch = 2'(ch); l.rm = rm; l.wm = wm; l.len = len; l.size = 2'(size);
      return l;
   endfunction

   task automatic busWrite(input logic [4:0] a, input logic [31:0] d);
      bus.iChipselect_n = 1'b0; bus.iWrite = 1'b1; bus.iAddress = a; bus.iWritedata = d;
      @(posedge iClk); #1;
      bus.iChipselect_n = 1'b1; bus.iWrite = 1'b0;
   endtask

   // Read through the scoreboard: expectation queued at issue, compared when data returns
   task automatic busRead(input logic [4:0] a, input logic [31:0] exp, input string name);
      readQ.push_back(exp);
      readNameQ.push_back(name);
      bus.iChipselect_n = 1'b0; bus.iRead = 1'b1; bus.iAddress = a;
      @(posedge iClk); #1;
      bus.iChipselect_n = 1'b1; bus.iRead = 1'b0;
      lastReadExp = readQ[0];
      check(readNameQ.pop_front(), bus.oReaddata, readQ.pop_front());
   endtask

   task automatic waitStart(input string name);
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(posedge iClk); #1;
         if (bus.oStart) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s actual=no_oStart required=oStart_within_20_cycles", name);
      end
   endtask

   task automatic pulseDone();
      bus.iMW_done = 1'b1;
      @(posedge iClk); #1;
      bus.iMW_done = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge iClk); #1; end
   endtask

   // Launch monitor: each oStart pops the expected descriptor
   always @(negedge iClk) begin
      cycleCnt++;
      if (bus.oStart) begin
         startCount++;
         check("start_single_cycle", 32'(prevStart), 32'd0);
         if (lastStartCycle >= 0) begin
            checks++;
            if (cycleCnt - lastStartCycle < 4) begin
               errors++;
               $display("FAIL start_gap actual=%0d required>=4", cycleCnt - lastStartCycle);
            end
         end
         lastStartCycle = cycleCnt;
         if (launchQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_start actual=ch%0d required=no_start", bus.oChannel);
         end else begin
            monExp = launchQ.pop_front();
            check("launch_channel", 32'(bus.oChannel), 32'(monExp.ch));
            check("launch_rm", bus.oRM_startaddress, monExp.rm);
            check("launch_wm", bus.oWM_startaddress, monExp.wm);
            check("launch_len", bus.oLength, monExp.len);
            check("launch_size", 32'(bus.oSize), 32'(monExp.size));
         end
      end
      prevStart = bus.oStart;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int sc;
      vecs[0]  = '{1'b0, addr(0, 0), 32'h0,        32'h0,      "rst_ch0_rm"};
      vecs[1]  = '{1'b0, addr(1, 7), 32'h0,        32'h0,      "rst_ch1_stat"};
      vecs[2]  = '{1'b0, addr(2, 3), 32'h0,        32'h0,      "rst_ch2_ctrl"};
      vecs[3]  = '{1'b1, addr(0, 0), 32'h1000,     32'h1000,   "ch0_rm"};
      vecs[4]  = '{1'b1, addr(0, 1), 32'h2000,     32'h2000,   "ch0_wm"};
      vecs[5]  = '{1'b1, addr(0, 2), 32'd64,       32'd64,     "ch0_len"};
      vecs[6]  = '{1'b1, addr(0, 3), 32'hFFFFFFFE, 32'hE,      "ch0_ctrl_mask"};
      vecs[7]  = '{1'b1, addr(0, 4), 32'h1234,     32'h0,      "ch0_off4_unmapped"};
      vecs[8]  = '{1'b1, addr(3, 0), 32'h55,       32'h0,      "ch3_unmapped"};
      vecs[9]  = '{1'b1, addr(2, 0), 32'hABCD,     32'hABCD,   "ch2_rm"};
      vecs[10] = '{1'b1, addr(0, 7), 32'hF,        32'h0,      "ch0_stat_ro"};
      vecs[11] = '{1'b0, addr(0, 0), 32'h0,        32'h1000,   "ch0_rm_no_alias"};

      bus.iChipselect_n = 1'b1; bus.iWrite = 1'b0; bus.iRead = 1'b0;
      bus.iAddress = '0; bus.iWritedata = '0; bus.iMW_done = 1'b0;
      tick(3);
      check("rst_oStart", 32'(bus.oStart), 32'd0);
      check("rst_oIrq", 32'(bus.oIrq), 32'd0);
      check("rst_oReaddata", bus.oReaddata, 32'd0);
      check("rst_oLength", bus.oLength, 32'd0);
      iReset = 1'b0;
      tick(1);

      // Register table
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].doWrite) busWrite(vecs[i].addr, vecs[i].wdata);
         busRead(vecs[i].addr, vecs[i].expRead, vecs[i].name);
      end
      busRead(addr(3, 7), 32'h0, "ch3_stat_unmapped");

      // Write with iRead also high: write only, read data holds
      bus.iChipselect_n = 1'b0; bus.iWrite = 1'b1; bus.iRead = 1'b1;
      bus.iAddress = addr(2, 1); bus.iWritedata = 32'h77;
      @(posedge iClk); #1;
      bus.iChipselect_n = 1'b1; bus.iWrite = 1'b0; bus.iRead = 1'b0;
      check("wr_rd_holds_readdata", bus.oReaddata, lastReadExp);
      busRead(addr(2, 1), 32'h77, "wr_rd_write_taken");

      // Single transfer on ch0 with interrupt
      launchQ.push_back(mk(0, 32'h1000, 32'h2000, 32'd64, 2));
      busWrite(addr(0, 3), 32'h0B);
      waitStart("t1_start");
      tick(1);
      check("t1_start_low", 32'(bus.oStart), 32'd0);
      busRead(addr(0, 7), 32'h2, "t1_stat_busy");
      busWrite(addr(0, 0), 32'hDEAD);
      busRead(addr(0, 0), 32'h1000, "busy_rm_protected");
      busWrite(addr(1, 0), 32'h3000);
      busRead(addr(1, 0), 32'h3000, "other_ch_rm_accepted");
      pulseDone();
      tick(1);
      check("irq_registered_latency", 32'(bus.oIrq), 32'd0);
      tick(1);
      check("t1_irq_set", 32'(bus.oIrq), 32'd1);
      busRead(addr(0, 7), 32'h1, "t1_stat_done");
      busRead(addr(0, 3), 32'h0A, "t1_go_cleared");
      busWrite(addr(0, 7), 32'h1);
      busRead(addr(0, 7), 32'h0, "t1_w1c");
      check("t1_irq_cleared", 32'(bus.oIrq), 32'd0);

      // Stray iMW_done while idle
      sc = startCount;
      pulseDone();
      tick(3);
      busRead(addr(0, 7), 32'h0, "stray_done_stat");
      check("stray_done_no_start", 32'(startCount), 32'(sc));

      // Zero-length arm
      busWrite(addr(1, 2), 32'h0);
      sc = startCount;
      busWrite(addr(1, 3), 32'h1);
      tick(6);
      check("zl_no_start", 32'(startCount), 32'(sc));
      busRead(addr(1, 7), 32'h5, "zl_stat_err_done");
      busRead(addr(1, 3), 32'h0, "zl_go_reads_0");
      busWrite(addr(1, 7), 32'h1);
      busRead(addr(1, 7), 32'h0, "zl_w1c");

      // Round-robin: ch2 armed before ch1, ch1 still wins after ch0
      busWrite(addr(1, 1), 32'h4000);
      busWrite(addr(1, 2), 32'd16);
      busWrite(addr(2, 2), 32'd8);
      launchQ.push_back(mk(0, 32'h1000, 32'h2000, 32'd64, 2));
      busWrite(addr(0, 3), 32'h09);
      waitStart("rr_a_ch0");
      tick(1);
      launchQ.push_back(mk(1, 32'h3000, 32'h4000, 32'd16, 0));
      launchQ.push_back(mk(2, 32'hABCD, 32'h77, 32'd8, 1));
      busWrite(addr(2, 3), 32'h05);
      busWrite(addr(1, 3), 32'h01);
      pulseDone();
      waitStart("rr_b_ch1");
      tick(1);
      pulseDone();
      waitStart("rr_c_ch2");
      tick(1);
      // ch1 armed before ch0, but after a ch2 grant the search wraps to ch0
      launchQ.push_back(mk(0, 32'h1000, 32'h2000, 32'd64, 2));
      launchQ.push_back(mk(1, 32'h3000, 32'h4000, 32'd16, 0));
      busWrite(addr(1, 3), 32'h01);
      busWrite(addr(0, 3), 32'h09);
      pulseDone();
      waitStart("rr_d_ch0");
      tick(1);
      pulseDone();
      waitStart("rr_e_ch1");
      tick(1);
      pulseDone();
      tick(3);
      check("rr_irq_masked", 32'(bus.oIrq), 32'd0);

      // W1C in the same cycle FINISH sets DONE: set wins
      launchQ.push_back(mk(2, 32'hABCD, 32'h77, 32'd8, 1));
      busWrite(addr(2, 3), 32'h05);
      waitStart("col_start");
      tick(1);
      pulseDone();
      busWrite(addr(2, 7), 32'h1);
      busRead(addr(2, 7), 32'h1, "col_done_wins");
      busWrite(addr(2, 7), 32'h1);
      busRead(addr(2, 7), 32'h0, "col_later_w1c");

      // Reset in the middle of WAIT
      launchQ.push_back(mk(1, 32'h3000, 32'h4000, 32'd16, 2));
      busWrite(addr(1, 3), 32'h0B);
      waitStart("rst_mid_start");
      tick(1);
      busRead(addr(1, 0), 32'h3000, "rst_mid_pre_read");
      check("rst_mid_pre_irq", 32'(bus.oIrq), 32'd1);
      #2 iReset = 1'b1;
      #1;
      check("rst_mid_oRM", bus.oRM_startaddress, 32'h0);
      check("rst_mid_oWM", bus.oWM_startaddress, 32'h0);
      check("rst_mid_oLength", bus.oLength, 32'h0);
      check("rst_mid_oChannel", 32'(bus.oChannel), 32'h0);
      check("rst_mid_oSize", 32'(bus.oSize), 32'h0);
      check("rst_mid_oIrq", 32'(bus.oIrq), 32'h0);
      check("rst_mid_oReaddata", bus.oReaddata, 32'h0);
      #3 iReset = 1'b0;
      tick(1);
      busRead(addr(1, 7), 32'h0, "rst_mid_stat");
      busRead(addr(1, 0), 32'h0, "rst_mid_rm");
      busWrite(addr(2, 0), 32'h9000);
      busWrite(addr(2, 1), 32'hA000);
      busWrite(addr(2, 2), 32'd32);
      launchQ.push_back(mk(2, 32'h9000, 32'hA000, 32'd32, 2));
      busWrite(addr(2, 3), 32'h0B);
      waitStart("post_rst_start");
      tick(1);
      pulseDone();
      tick(2);
      check("post_rst_irq", 32'(bus.oIrq), 32'd1);
      busRead(addr(2, 7), 32'h1, "post_rst_stat");

      tick(2);
      check("launch_queue_empty", 32'(launchQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
